// File: rtl/gray_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : gray_counter_n
// Purpose  : WIDTH-bit up/down Gray counter with Gray-coded parallel load,
//            sticky overflow/underflow flags and a one-cycle wrap pulse.
//            Define GRAY_CNT_SAT_EN for saturating (non-wrapping) counting.
// Revision : 1.0  initial release
// ============================================================================
module gray_counter_n #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Clr,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] C_MAX = '1;
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_bin;

    // Each binary bit is the parity of the Gray bits at and above it.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_gray2bin
            assign load_bin[gi] = ^(LoadVal >> gi);
        end
    endgenerate

    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wrap_d = 1'b0;

        // Clear first so a flag set on the same edge wins.
        if (Clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        if (Load) begin
            cnt_d = load_bin;
        end else if (En) begin
            if (Up) begin
                if (cnt_q == C_MAX) begin
                    ovf_d  = 1'b1;
                    wrap_d = 1'b1;
`ifdef GRAY_CNT_SAT_EN
                    cnt_d  = cnt_q;
`else
                    cnt_d  = cnt_q + C_ONE;
`endif
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end else begin
                if (cnt_q == '0) begin
                    unf_d  = 1'b1;
                    wrap_d = 1'b1;
`ifdef GRAY_CNT_SAT_EN
                    cnt_d  = cnt_q;
`else
                    cnt_d  = cnt_q - C_ONE;
`endif
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            wrap_q <= wrap_d;
        end
    end

    assign Output    = cnt_q ^ (cnt_q >> 1);
    assign Binary    = cnt_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_counter_n
// Purpose  : Bench for gray_counter_n, WIDTH=3 and WIDTH=4 instances driven
//            by shared controls, checked against a reference model each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_gray_counter_n;

    logic       Clk = 1'b0;
    logic       Reset, En, Up, Load, Clr;
    logic [2:0] lv3;
    logic [3:0] lv4;
    logic [2:0] out3, bin3;
    logic [3:0] out4, bin4;
    logic       ovf3, unf3, wrp3, ovf4, unf4, wrp4;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 Clk = ~Clk;

    gray_counter_n #(.WIDTH(3)) u3 (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadVal(lv3),
        .Clr(Clr), .Output(out3), .Binary(bin3), .Overflow(ovf3),
        .Underflow(unf3), .Wrap(wrp3)
    );

    gray_counter_n #(.WIDTH(4)) u4 (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadVal(lv4),
        .Clr(Clr), .Output(out4), .Binary(bin4), .Overflow(ovf4),
        .Underflow(unf4), .Wrap(wrp4)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (index 0: WIDTH 3, 1: WIDTH 4) ------
    int unsigned m_cnt [2] = '{0, 0};
    bit          m_ovf [2] = '{0, 0};
    bit          m_unf [2] = '{0, 0};
    bit          m_wrap[2] = '{0, 0};
    bit          sat_mode;

    initial begin
`ifdef GRAY_CNT_SAT_EN
        sat_mode = 1'b1;
`else
        sat_mode = 1'b0;
`endif
    end

    function automatic int unsigned gray_of(input int unsigned b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned bin_of(input int unsigned g);
        int unsigned b = 0;
        for (int s = 0; s < 32; s++) b ^= (g >> s);
        return b;
    endfunction

    always @(posedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            int unsigned top;
            top = (k == 0) ? 7 : 15;
            if (Reset) begin
                m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_wrap[k] = 0;
            end else begin
                m_wrap[k] = 0;
                if (Clr) begin m_ovf[k] = 0; m_unf[k] = 0; end
                if (Load) begin
                    m_cnt[k] = bin_of((k == 0) ? int'(lv3) : int'(lv4));
                end else if (En && Up) begin
                    if (m_cnt[k] == top) begin
                        m_ovf[k] = 1; m_wrap[k] = 1;
                        m_cnt[k] = sat_mode ? top : 0;
                    end else m_cnt[k] = m_cnt[k] + 1;
                end else if (En) begin
                    if (m_cnt[k] == 0) begin
                        m_unf[k] = 1; m_wrap[k] = 1;
                        m_cnt[k] = sat_mode ? 0 : top;
                    end else m_cnt[k] = m_cnt[k] - 1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_on) begin
            chk("m3_out",  out3, gray_of(m_cnt[0]));
            chk("m3_bin",  bin3, m_cnt[0]);
            chk("m3_ovf",  ovf3, m_ovf[0]);
            chk("m3_unf",  unf3, m_unf[0]);
            chk("m3_wrap", wrp3, m_wrap[0]);
            chk("m4_out",  out4, gray_of(m_cnt[1]));
            chk("m4_bin",  bin4, m_cnt[1]);
            chk("m4_ovf",  ovf4, m_ovf[1]);
            chk("m4_unf",  unf4, m_unf[1]);
            chk("m4_wrap", wrp4, m_wrap[1]);
        end
    end

    // ---------------- directed stimulus with literal expectations --------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1; tick(); Reset = 0;
    endtask

    initial begin
        int unsigned seq [9];
        int          pulses;
        Reset = 1; En = 0; Up = 1; Load = 0; Clr = 0; lv3 = '0; lv4 = '0;
        tick(); tick();
        chk_on = 1'b1;
        Reset = 0;
        chk("rst_out", out3, 0);
        chk("rst_bin", bin3, 0);
        chk("rst_flags", {ovf3, unf3, wrp3}, 0);

        // Count up 9 (wrap mode) / 10 (saturating mode) steps from zero.
`ifndef GRAY_CNT_SAT_EN
        seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
        En = 1; Up = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("up_seq", out3, seq[i]);
            chk("up_ovf", ovf3, (i >= 7) ? 1 : 0);
            chk("up_wrap", wrp3, (i == 7) ? 1 : 0);
        end
        En = 0;
`else
        En = 1; Up = 1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wrp3) pulses++;
        end
        En = 0;
        chk("sat_bin", bin3, 7);
        chk("sat_out", out3, 3'b100);
        chk("sat_ovf", ovf3, 1);
        chk("sat_pulses", pulses, 3);
`endif

        // One down step from reset.
        do_reset();
        Up = 0; En = 1; tick(); En = 0;
`ifndef GRAY_CNT_SAT_EN
        chk("dn_out", out3, 3'b100);
        chk("dn_bin", bin3, 7);
        chk("dn_out4", out4, 4'b1000);
`else
        chk("dn_out", out3, 0);
        chk("dn_bin", bin3, 0);
        chk("dn_out4", out4, 0);
`endif
        chk("dn_unf", unf3, 1);
        chk("dn_wrap", wrp3, 1);
        chk("dn_ovf", ovf3, 0);

        // Load beats En; then step up from max.
        do_reset();
        Load = 1; En = 1; Up = 1; lv4 = 4'b1000; lv3 = 3'b100; tick(); Load = 0;
        chk("ld_bin4", bin4, 15);
        chk("ld_out4", out4, 4'b1000);
        chk("ld_bin3", bin3, 7);
        tick(); En = 0;
`ifndef GRAY_CNT_SAT_EN
        chk("ld_up_out4", out4, 0);
`else
        chk("ld_up_out4", out4, 4'b1000);
`endif
        chk("ld_up_ovf4", ovf4, 1);

        // Clr on the same edge as a wrap: set wins; then Clr alone clears.
        Load = 1; lv3 = 3'b100; tick(); Load = 0;
        chk("clr_pre_ovf", ovf3, 1);
        Clr = 1; En = 1; Up = 1; tick();
        chk("clr_wrap_ovf", ovf3, 1);
        chk("clr_wrap_pulse", wrp3, 1);
        En = 0; tick(); Clr = 0;
        chk("clr_only_ovf", ovf3, 0);

        // Reset overrides Load/En/Clr at cnt = 5.
        Load = 1; lv3 = 3'b111; tick(); Load = 0;
        chk("ld5_bin", bin3, 5);
        Reset = 1; Load = 1; En = 1; Clr = 1; tick();
        Reset = 0; Load = 0; En = 0; Clr = 0;
        chk("rst_all_bin", bin3, 0);
        chk("rst_all_out", out3, 0);
        chk("rst_all_flags", {ovf3, unf3, wrp3}, 0);

        // Mixed traffic with direction changes, checked by the model.
        for (int i = 0; i < 200; i++) begin
            En   = ($urandom_range(0, 3) != 0);
            Up   = $urandom_range(0, 1);
            Load = ($urandom_range(0, 15) == 0);
            Clr  = ($urandom_range(0, 7) == 0);
            lv3  = 3'($urandom_range(0, 7));
            lv4  = 4'($urandom_range(0, 15));
            tick();
        end
        En = 0; Load = 0; Clr = 0;
        tick();

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
